// File: rtl/wb_stage_regfile.sv
// -----------------------------------------------------------------------------
// wb_stage_regfile
//   Writeback end of the MEM/WB interface. Selects the writeback value from the
//   W-stage bundle, commits it to the architectural register file, and serves
//   two decode-stage read ports with same-cycle write-to-read bypass.
//   A committed-write counter is kept for performance monitoring.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   RegWriteW   write enable from MEM/WB
//   ResultSrcW  result select: 00 ALU, 01 load data, 10 PC+4, 11 zero
//   ALUResultW  ALU result
//   ReadDataW   load data
//   PCPlus4W    return address for JAL/JALR
//   RdW         destination register
//   A1D, A2D    decode read addresses (rs1, rs2)
//   RD1D, RD2D  decode read data (combinational, write-first bypass)
//   ResultW     selected writeback value (combinational, to forwarding mux)
//   WbCount     number of committed register writes (registered, wraps)
// -----------------------------------------------------------------------------
module wb_stage_regfile #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcW,
    input  logic [XLEN-1:0]   ALUResultW,
    input  logic [XLEN-1:0]   ReadDataW,
    input  logic [XLEN-1:0]   PCPlus4W,
    input  logic [ADDR_W-1:0] RdW,
    input  logic [ADDR_W-1:0] A1D,
    input  logic [ADDR_W-1:0] A2D,
    output logic [XLEN-1:0]   RD1D,
    output logic [XLEN-1:0]   RD2D,
    output logic [XLEN-1:0]   ResultW,
    output logic [CNT_W-1:0]  WbCount
);

    localparam int NREG = 2 ** ADDR_W;

    logic [XLEN-1:0]  regs [NREG];
    logic [CNT_W-1:0] wbCountQ;
    logic             we;
    logic             bypass1;
    logic             bypass2;

    // Writeback value select; stays live during reset since it is pure
    // combinational steering of the W-stage bundle.
    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    // Gating with rst both drops a write pending while reset is held and
    // disables the bypass, so reads during reset see the cleared array.
    assign we = RegWriteW && (RdW != '0) && rst;

    assign bypass1 = we && (A1D == RdW);
    assign bypass2 = we && (A2D == RdW);

    // x0 is forced to zero on the read side; the bypass terms already exclude
    // address 0 because we requires RdW != 0.
    always_comb begin
        RD1D = '0;
        if (A1D != '0) begin
            RD1D = bypass1 ? ResultW : regs[A1D];
        end
    end

    always_comb begin
        RD2D = '0;
        if (A2D != '0) begin
            RD2D = bypass2 ? ResultW : regs[A2D];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[RdW] <= ResultW;
        end
    end

    // Free-running modulo-2^CNT_W count of committed writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbCountQ <= '0;
        end else if (we) begin
            wbCountQ <= wbCountQ + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign WbCount = wbCountQ;

endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] WbCount;

    // Narrow-counter instance sharing the same stimulus, for wrap checks.
    logic [31:0] RD1Dn;
    logic [31:0] RD2Dn;
    logic [31:0] ResultWn;
    logic [3:0]  WbCount4;

    int nChecks = 0;
    int nFails  = 0;

    wb_stage_regfile #(.XLEN(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
        .ResultW(ResultW), .WbCount(WbCount)
    );

    wb_stage_regfile #(.XLEN(32), .ADDR_W(5), .CNT_W(4)) dutNarrow (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .A1D(A1D), .A2D(A2D), .RD1D(RD1Dn), .RD2D(RD2Dn),
        .ResultW(ResultWn), .WbCount(WbCount4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        RegWriteW  = we;
        ResultSrcW = src;
        ALUResultW = alu;
        ReadDataW  = ld;
        PCPlus4W   = pc;
        RdW        = rd;
        A1D        = a1;
        A2D        = a2;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic doReset();
        idle();
        rst = 1'b0;
        stepEdge();
        rst = 1'b1;
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] expRes;
        logic [31:0] expRd1;
        logic [31:0] expRd2;
        logic [31:0] expCnt;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] expCnt;

        // mux select, no writes
        vecs[0]  = '{1'b0, 2'b00, 32'h11, 32'h22, 32'h1004, 5'd0, 5'd0, 5'd0, 32'h11, 32'h0, 32'h0, 32'd0};
        vecs[1]  = '{1'b0, 2'b01, 32'h11, 32'h22, 32'h1004, 5'd0, 5'd0, 5'd0, 32'h22, 32'h0, 32'h0, 32'd0};
        vecs[2]  = '{1'b0, 2'b10, 32'h11, 32'h22, 32'h1004, 5'd0, 5'd0, 5'd0, 32'h1004, 32'h0, 32'h0, 32'd0};
        vecs[3]  = '{1'b0, 2'b11, 32'h11, 32'h22, 32'h1004, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'd0};
        // bypass to both ports, then array holds the value
        vecs[4]  = '{1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        vecs[5]  = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        // write to x0: no bypass, no count
        vecs[6]  = '{1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'd1};
        vecs[7]  = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hDEADBEEF, 32'd1};
        // commits from each source, bypass on one port only
        vecs[8]  = '{1'b1, 2'b01, 32'h0, 32'hCAFE0003, 32'h0, 5'd3, 5'd3, 5'd5, 32'hCAFE0003, 32'hCAFE0003, 32'hDEADBEEF, 32'd2};
        vecs[9]  = '{1'b1, 2'b10, 32'h0, 32'h0, 32'h1004, 5'd6, 5'd3, 5'd6, 32'h1004, 32'hCAFE0003, 32'h1004, 32'd3};
        vecs[10] = '{1'b1, 2'b11, 32'h77, 32'h0, 32'h0, 5'd7, 5'd7, 5'd6, 32'h0, 32'h0, 32'h1004, 32'd4};
        // overwrite: bypass wins over the stale array value
        vecs[11] = '{1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3, 32'h55, 32'h55, 32'h55, 32'd5};
        vecs[12] = '{1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd6, 32'h0, 32'h55, 32'h1004, 32'd5};

        // ---- 1. reset, then read every address ----
        idle();
        rst = 1'b0;
        #12;
        check("reset_cnt_during", WbCount, 32'd0);
        rst = 1'b1;
        stepEdge();
        for (int a = 0; a < 32; a++) begin
            A1D = a[4:0];
            A2D = 5'(31 - a);
            #1;
            check($sformatf("reset_rd1_x%0d", a), RD1D, 32'h0);
            check($sformatf("reset_rd2_x%0d", 31 - a), RD2D, 32'h0);
        end
        check("reset_cnt", WbCount, 32'd0);
        check("reset_cnt4", {28'h0, WbCount4}, 32'd0);

        // ---- 2-4. table-driven vectors ----
        stepEdge();
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].src, vecs[i].alu, vecs[i].ld, vecs[i].pc,
                  vecs[i].rd, vecs[i].a1, vecs[i].a2);
            #1;
            check($sformatf("vec%0d_result", i), ResultW, vecs[i].expRes);
            check($sformatf("vec%0d_rd1", i), RD1D, vecs[i].expRd1);
            check($sformatf("vec%0d_rd2", i), RD2D, vecs[i].expRd2);
            stepEdge();
            check($sformatf("vec%0d_cnt", i), WbCount, vecs[i].expCnt);
        end

        // ---- 5. counter: 10 commits with idles, then wrap of 4-bit counter ----
        doReset();
        expCnt = 0;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 2'b00, 32'h100 * i, 32'h0, 32'h0, 5'(i), 5'd0, 5'd0);
            stepEdge();
            expCnt++;
            if (i % 3 == 0) begin
                idle();
                stepEdge();
            end
        end
        idle();
        #1;
        check("cnt_after_10", WbCount, 32'd10);
        check("cnt4_after_10", {28'h0, WbCount4}, 32'd10);
        for (int i = 1; i <= 10; i++) begin
            A1D = 5'(i);
            A2D = 5'(11 - i);
            #1;
            check($sformatf("cnt_read_x%0d", i), RD1D, 32'h100 * i);
            check($sformatf("cnt_read_x%0d_p2", 11 - i), RD2D, 32'h100 * (11 - i));
        end
        for (int i = 11; i <= 15; i++) begin
            drive(1'b1, 2'b00, 32'h100 * i, 32'h0, 32'h0, 5'(i), 5'd0, 5'd0);
            stepEdge();
        end
        idle();
        #1;
        check("cnt4_at_15", {28'h0, WbCount4}, 32'd15);
        drive(1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd16, 5'd0, 5'd0);
        stepEdge();
        idle();
        #1;
        check("cnt4_wrap", {28'h0, WbCount4}, 32'd0);
        check("cnt_16", WbCount, 32'd16);

        // ---- 6. reset asserted with a commit pending ----
        doReset();
        drive(1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd7, 5'd0, 5'd0);
        stepEdge();
        idle();
        A1D = 5'd7;
        #1;
        check("midrst_x7_written", RD1D, 32'h1234);
        check("midrst_cnt_before", WbCount, 32'd1);
        drive(1'b1, 2'b00, 32'h5678, 32'h0, 32'h0, 5'd8, 5'd7, 5'd8);
        #1;
        check("midrst_bypass_pre", RD2D, 32'h5678);
        rst = 1'b0;
        #1;
        check("midrst_x7_during", RD1D, 32'h0);
        check("midrst_x8_no_bypass", RD2D, 32'h0);
        check("midrst_cnt_during", WbCount, 32'd0);
        check("midrst_result_live", ResultW, 32'h5678);
        stepEdge();
        rst = 1'b1;
        idle();
        A1D = 5'd7;
        A2D = 5'd8;
        stepEdge();
        check("midrst_x7_after", RD1D, 32'h0);
        check("midrst_x8_after", RD2D, 32'h0);
        check("midrst_cnt_after", WbCount, 32'd0);
        drive(1'b1, 2'b00, 32'h99, 32'h0, 32'h0, 5'd8, 5'd7, 5'd8);
        stepEdge();
        idle();
        A2D = 5'd8;
        #1;
        check("midrst_first_commit_x8", RD2D, 32'h99);
        check("midrst_first_commit_cnt", WbCount, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
